// File: rtl/pipe_addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_addsub_pkg
// Purpose  : Shared constants and the chunk adder used by every pipeline
//            stage of pipe_addsub.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Widest chunk a single stage may resolve.
  localparam int unsigned MAX_CHUNK = 32;

  // Adds the low w bits of a and b plus cin. Bit w of the result is the
  // carry out of that w-bit slice and bits [w-1:0] are the slice sum.
  function automatic logic [MAX_CHUNK:0] chunk_add(
    input logic [MAX_CHUNK-1:0] a,
    input logic [MAX_CHUNK-1:0] b,
    input logic                 cin,
    input int unsigned          w
  );
    logic [MAX_CHUNK:0] am;
    logic [MAX_CHUNK:0] bm;
    am = '0;
    bm = '0;
    for (int unsigned i = 0; i < MAX_CHUNK; i++) begin
      if (i < w) begin
        am[i] = a[i];
        bm[i] = b[i];
      end
    end
    return am + bm + {{MAX_CHUNK{1'b0}}, cin};
  endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_stage.sv
`default_nettype none
// ============================================================================
// Module   : addsub_stage
// Purpose  : One CHUNK-bit slice of the pipelined adder: adds the lowest
//            remaining operand chunk to the incoming carry, shifts the sum
//            chunk in from the top, and registers everything behind a
//            valid/ready handshake with full bubble collapse.
//            With PIPE_ADDSUB_OVF_EN defined, the carry into the slice MSB is
//            also registered (meaningful in the last stage only).
// Revision : 1.0 - initial release
// ============================================================================
module addsub_stage
  import pipe_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic             up_carry,
  input  logic [WIDTH-1:0] up_a,
  input  logic [WIDTH-1:0] up_b,
  input  logic [WIDTH-1:0] up_sum,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic             dn_carry,
`ifdef PIPE_ADDSUB_OVF_EN
  output logic             dn_msb_cin,
`endif
  output logic [WIDTH-1:0] dn_a,
  output logic [WIDTH-1:0] dn_b,
  output logic [WIDTH-1:0] dn_sum
);

  logic             valid_q, valid_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             msb_cin_q, msb_cin_d;

  logic [MAX_CHUNK-1:0] a_chunk;
  logic [MAX_CHUNK-1:0] b_chunk;
  logic [MAX_CHUNK:0]   add_full;
  logic [MAX_CHUNK:0]   add_low;
  logic [WIDTH-1:0]     sum_chunk;
  logic                 load;

  // The slot frees up when empty or when its content is leaving this cycle.
  assign up_ready = ~valid_q | dn_ready;
  assign load     = up_valid & up_ready;

  // Slice arithmetic and next-state selection; data only moves on a load so
  // a stalled result stays stable.
  always_comb begin
    a_chunk              = '0;
    b_chunk              = '0;
    a_chunk[CHUNK-1:0]   = up_a[CHUNK-1:0];
    b_chunk[CHUNK-1:0]   = up_b[CHUNK-1:0];
    add_full             = chunk_add(a_chunk, b_chunk, up_carry, CHUNK);
    // Carry into the slice MSB: the carry out of the lower CHUNK-1 bits.
    add_low              = chunk_add(a_chunk, b_chunk, up_carry, CHUNK - 1);
    sum_chunk            = WIDTH'(add_full[CHUNK-1:0]) << (WIDTH - CHUNK);

    valid_d   = valid_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    msb_cin_d = msb_cin_q;

    if (up_ready) begin
      valid_d = up_valid;
    end
    if (load) begin
      carry_d   = add_full[CHUNK];
      msb_cin_d = add_low[CHUNK-1];
      // Consumed operand chunks drop off the bottom; the finished sum chunk
      // enters at the top so chunk 0 reaches bit 0 after the final stage.
      a_d       = up_a >> CHUNK;
      b_d       = up_b >> CHUNK;
      sum_d     = (up_sum >> CHUNK) | sum_chunk;
    end
  end

  // Stage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      msb_cin_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      carry_q   <= carry_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      msb_cin_q <= msb_cin_d;
    end
  end

  assign dn_valid   = valid_q;
  assign dn_carry   = carry_q;
  assign dn_a       = a_q;
  assign dn_b       = b_q;
  assign dn_sum     = sum_q;
`ifdef PIPE_ADDSUB_OVF_EN
  assign dn_msb_cin = msb_cin_q;
`endif

endmodule
`default_nettype wire

// File: rtl/pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module   : pipe_addsub
// Purpose  : Pipelined ripple-carry adder/subtractor, WIDTH bits resolved
//            CHUNK bits per stage, valid/ready stream on both sides.
//            Subtraction is A + ~B + ~cin, so the carry out is ~borrow.
//            Option macro PIPE_ADDSUB_OVF_EN adds out_ovf (signed overflow).
// Revision : 1.0 - initial release
// ============================================================================
module pipe_addsub
  import pipe_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef PIPE_ADDSUB_OVF_EN
  output logic             out_ovf,
`endif
  output logic [WIDTH:0]   out_sum
);

  localparam int unsigned STAGES = (CHUNK == 0) ? 1 : WIDTH / CHUNK;

  if (WIDTH < 2 || CHUNK == 0 || CHUNK > MAX_CHUNK || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("pipe_addsub: WIDTH must be >= 2 and a multiple of CHUNK (1..MAX_CHUNK)");
  end

  // Index k is the input side of stage k; index STAGES is the output side.
  logic [STAGES:0]            valid_c;
  logic [STAGES:0]            ready_c;
  logic [STAGES:0]            carry_c;
  logic [STAGES:0][WIDTH-1:0] a_c;
  logic [STAGES:0][WIDTH-1:0] b_c;
  logic [STAGES:0][WIDTH-1:0] sum_c;
`ifdef PIPE_ADDSUB_OVF_EN
  logic [STAGES-1:0]          msb_cin_c;
`endif

  // Operand conditioning: subtract is add of the complement with inverted cin.
  assign valid_c[0]      = in_valid;
  assign carry_c[0]      = (in_sub == OP_SUB) ? ~in_cin : in_cin;
  assign a_c[0]          = in_a;
  assign b_c[0]          = (in_sub == OP_SUB) ? ~in_b : in_b;
  assign sum_c[0]        = '0;
  assign ready_c[STAGES] = out_ready;
  assign in_ready        = ready_c[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    addsub_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .up_valid   (valid_c[k]),
      .up_ready   (ready_c[k]),
      .up_carry   (carry_c[k]),
      .up_a       (a_c[k]),
      .up_b       (b_c[k]),
      .up_sum     (sum_c[k]),
      .dn_valid   (valid_c[k+1]),
      .dn_ready   (ready_c[k+1]),
      .dn_carry   (carry_c[k+1]),
`ifdef PIPE_ADDSUB_OVF_EN
      .dn_msb_cin (msb_cin_c[k]),
`endif
      .dn_a       (a_c[k+1]),
      .dn_b       (b_c[k+1]),
      .dn_sum     (sum_c[k+1])
    );
  end

  assign out_valid = valid_c[STAGES];
  assign out_sum   = {carry_c[STAGES], sum_c[STAGES]};
`ifdef PIPE_ADDSUB_OVF_EN
  assign out_ovf   = msb_cin_c[STAGES-1] ^ carry_c[STAGES];
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_addsub
// Purpose  : Self-checking bench for pipe_addsub (WIDTH=4/CHUNK=2 main
//            instance, plus 8-bit single-stage and 8-stage instances).
//            Honours PIPE_ADDSUB_OVF_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_addsub;
  import pipe_addsub_pkg::*;

  localparam int W  = 4;
  localparam int C  = 2;
  localparam int ST = W / C;

  typedef struct {
    logic [W:0] sum;
    logic       ovf;
    int         acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic in_cin = 1'b0;
  logic in_sub = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [W:0] out_sum;

  logic       x_valid = 1'b0;
  logic [7:0] x_a = '0;
  logic [7:0] x_b = '0;
  logic       xs_rdy, xm_rdy, xs_valid, xm_valid;
  logic [8:0] xs_sum, xm_sum;

`ifdef PIPE_ADDSUB_OVF_EN
  logic out_ovf, xs_ovf, xm_ovf;
`endif

  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;
  int   rmode  = 1;
  bit   lat_chk = 1'b1;
  exp_t q[$];

  always #5 clk = ~clk;

  pipe_addsub #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef PIPE_ADDSUB_OVF_EN
    .out_ovf(out_ovf),
`endif
    .out_sum(out_sum)
  );

  pipe_addsub #(.WIDTH(8), .CHUNK(8)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .in_valid(x_valid), .in_ready(xs_rdy),
    .in_a(x_a), .in_b(x_b), .in_cin(1'b0), .in_sub(OP_ADD),
    .out_valid(xs_valid), .out_ready(1'b1),
`ifdef PIPE_ADDSUB_OVF_EN
    .out_ovf(xs_ovf),
`endif
    .out_sum(xs_sum)
  );

  pipe_addsub #(.WIDTH(8), .CHUNK(1)) dut_m (
    .clk(clk), .rst_n(rst_n),
    .in_valid(x_valid), .in_ready(xm_rdy),
    .in_a(x_a), .in_b(x_b), .in_cin(1'b0), .in_sub(OP_ADD),
    .out_valid(xm_valid), .out_ready(1'b1),
`ifdef PIPE_ADDSUB_OVF_EN
    .out_ovf(xm_ovf),
`endif
    .out_sum(xm_sum)
  );

  // Reference: add is A+B+cin; sub is A-B-cin with bit W = no-borrow.
  function automatic logic [W:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
    int unsigned ia, ib, ic;
    logic        borrow;
    ia = a; ib = b; ic = cin;
    if (sub == OP_ADD) return (W+1)'(ia + ib + ic);
    borrow = (ia < ib + ic);
    return {~borrow, W'(ia - ib - ic)};
  endfunction

  // Reference: signed result outside the W-bit two's-complement range.
  function automatic logic model_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic cin, input logic sub);
    int sa, sb, r;
    sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
    sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
    r  = (sub == OP_SUB) ? sa - sb - int'(cin) : sa + sb + int'(cin);
    return (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub);
    bit ok;
    int n;
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 1000) begin
      @(negedge clk);
      ok = (in_ready === 1'b1);
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      total++;
      assert (ok) passed++;
      else $error("FAIL send_timeout: accepted=%b after %0d cycles, need 1", ok, n);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    rmode    = 1;
    in_valid = 1'b0;
    n        = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    assert (q.size() == 0) passed++;
    else $error("FAIL drain: %0d results outstanding, need 0", q.size());
  endtask

  initial begin
    fork
      forever begin
        @(posedge clk);
        cyc++;
      end
      forever begin
        @(posedge clk);
        #1;
        if (rmode == 0)      out_ready = 1'b0;
        else if (rmode == 1) out_ready = 1'b1;
        else                 out_ready = 1'($urandom_range(0, 1));
      end
      begin : monitor
        bit          stall_prev = 1'b0;
        bit          hold_prev  = 1'b0;
        logic [W:0]  prev_sum   = '0;
        logic [2*W+1:0] held    = '0;
        exp_t        e;
        forever begin
          @(negedge clk);
          if (!rst_n) begin
            total++;
            assert (out_valid === 1'b0 && out_sum === '0 && in_ready === 1'b1) passed++;
            else $error("FAIL reset_state: out_valid=%b out_sum=%h in_ready=%b, need 0/00/1",
                        out_valid, out_sum, in_ready);
            q.delete();
            stall_prev = 1'b0;
            hold_prev  = 1'b0;
          end else begin
            total++;
            assert (in_ready === 1'b1 || (q.size() == ST && out_ready === 1'b0)) passed++;
            else $error("FAIL ready_chain: in_ready=%b with %0d in flight, out_ready=%b, need 1 unless full and stalled",
                        in_ready, q.size(), out_ready);
            if (stall_prev) begin
              total++;
              assert (out_valid === 1'b1 && out_sum === prev_sum) passed++;
              else $error("FAIL stall_hold: out_valid=%b out_sum=%h, need 1/%h", out_valid, out_sum, prev_sum);
            end
            if (hold_prev) begin
              total++;
              assert (in_valid === 1'b1 && {in_a, in_b, in_cin, in_sub} === held) passed++;
              else $error("FAIL producer_hold: in=%h, need %h", {in_a, in_b, in_cin, in_sub}, held);
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
              total++;
              assert (q.size() > 0) passed++;
              else $error("FAIL spurious_out: out_sum=%h with nothing expected", out_sum);
              if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                assert (out_sum === e.sum) passed++;
                else $error("FAIL out_sum: got %b, need %b", out_sum, e.sum);
`ifdef PIPE_ADDSUB_OVF_EN
                total++;
                assert (out_ovf === e.ovf) passed++;
                else $error("FAIL out_ovf: got %b, need %b", out_ovf, e.ovf);
`endif
                if (lat_chk) begin
                  total++;
                  assert (cyc - e.acc == ST) passed++;
                  else $error("FAIL latency: got %0d, need %0d", cyc - e.acc, ST);
                end
              end
            end
            stall_prev = (out_valid === 1'b1 && out_ready === 1'b0);
            prev_sum   = out_sum;
            hold_prev  = (in_valid === 1'b1 && in_ready === 1'b0);
            held       = {in_a, in_b, in_cin, in_sub};
            if (in_valid === 1'b1 && in_ready === 1'b1) begin
              e.sum = model_sum(in_a, in_b, in_cin, in_sub);
              e.ovf = model_ovf(in_a, in_b, in_cin, in_sub);
              e.acc = cyc;
              q.push_back(e);
            end
          end
        end
      end
    join_none

    // Reset held for a few cycles, released just after an edge.
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed beats from the test plan.
    send(4'd9, 4'd7, 1'b1, OP_ADD);
    send(4'd5, 4'd3, 1'b0, OP_SUB);
    send(4'd3, 4'd5, 1'b0, OP_SUB);
    send(4'd7, 4'd1, 1'b0, OP_ADD);
    send(4'd15, 4'd15, 1'b1, OP_ADD);
    send(4'd0, 4'd15, 1'b1, OP_SUB);
    drain();

    // Exhaustive back-to-back stream, consumer always ready.
    for (int op = 0; op < 2; op++) begin
      for (int v = 0; v < 512; v++) begin
        logic [8:0] vv;
        vv = 9'(v);
        send(vv[8:5], vv[4:1], vv[0], 1'(op));
      end
    end
    drain();

    // Random valid/ready traffic.
    lat_chk = 1'b0;
    rmode   = 2;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 1) == 1)
        send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      else
        idle();
    end
    drain();
    lat_chk = 1'b1;

    // Reset with two beats in flight; the next beat must be the first result.
    send(4'd1, 4'd2, 1'b0, OP_ADD);
    send(4'd4, 4'd4, 1'b1, OP_ADD);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    assert (out_valid === 1'b0 && in_ready === 1'b1) passed++;
    else $error("FAIL reset_flush: out_valid=%b in_ready=%b, need 0/1", out_valid, in_ready);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(4'd6, 4'd9, 1'b1, OP_SUB);
    drain();
    repeat (4) idle();

    // 8-bit single-stage and 8-stage instances: 255 + 1.
    begin
      int         lat_s, lat_m;
      logic [8:0] sum_s, sum_m;
`ifdef PIPE_ADDSUB_OVF_EN
      logic       ovf_s, ovf_m;
      ovf_s = 1'bx;
      ovf_m = 1'bx;
`endif
      lat_s = 0; lat_m = 0; sum_s = 'x; sum_m = 'x;
      x_a = 8'd255; x_b = 8'd1; x_valid = 1'b1;
      @(negedge clk);
      total++;
      assert (xs_rdy === 1'b1 && xm_rdy === 1'b1) passed++;
      else $error("FAIL x_ready: single=%b multi=%b, need 1/1", xs_rdy, xm_rdy);
      @(posedge clk);
      #1;
      x_valid = 1'b0;
      for (int k = 1; k <= 20; k++) begin
        if (lat_s == 0 && xs_valid === 1'b1) begin
          lat_s = k;
          sum_s = xs_sum;
`ifdef PIPE_ADDSUB_OVF_EN
          ovf_s = xs_ovf;
`endif
        end
        if (lat_m == 0 && xm_valid === 1'b1) begin
          lat_m = k;
          sum_m = xm_sum;
`ifdef PIPE_ADDSUB_OVF_EN
          ovf_m = xm_ovf;
`endif
        end
        if (lat_s != 0 && lat_m != 0) break;
        @(posedge clk);
        #1;
      end
      total++;
      assert (lat_s == 1 && sum_s === 9'h100) passed++;
      else $error("FAIL w8c8: latency=%0d sum=%h, need 1/100", lat_s, sum_s);
      total++;
      assert (lat_m == 8 && sum_m === 9'h100) passed++;
      else $error("FAIL w8c1: latency=%0d sum=%h, need 8/100", lat_m, sum_m);
`ifdef PIPE_ADDSUB_OVF_EN
      total++;
      assert (ovf_s === 1'b0 && ovf_m === 1'b0) passed++;
      else $error("FAIL w8_ovf: single=%b multi=%b, need 0/0", ovf_s, ovf_m);
`endif
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
